regfile_write_arbiter: RTL and testbench
========================================

// Module: regfile_write_arbiter
// PURPOSE
//  Shares the single write port of the 8x8 register file between two requesters (e.g. ALU writeback, load path).
//  Each requester uses a valid/ready handshake; a round-robin arbiter grants one per cycle.
//  Also runs a sweep sequencer that clears every register one per cycle, using the per-register reset.
//  Outputs drive the register file's load, reset, write-address (addr_a) and data-in (d_in) inputs directly.
// PARAMETERS
//  DATA_W    8   register data width
//  ADDR_W    3   register address width
//  NUM_REGS  8   registers swept; must equal 2**ADDR_W
// PORTS
//  clk          in   1       rising-edge clock
//  reset_n      in   1       asynchronous, active-low reset
//  req0_valid   in   1       requester 0 has a write/clear command
//  req0_ready   out  1       requester 0 command accepted this cycle
//  req0_addr    in   ADDR_W  target register, requester 0
//  req0_data    in   DATA_W  write data, requester 0
//  req0_clr     in   1       1 = clear target register instead of writing it
//  req1_valid   in   1       same as req0_valid, requester 1
//  req1_ready   out  1       same as req0_ready, requester 1
//  req1_addr    in   ADDR_W  same as req0_addr, requester 1
//  req1_data    in   DATA_W  same as req0_data, requester 1
//  req1_clr     in   1       same as req0_clr, requester 1
//  sweep_start  in   1       single-cycle pulse: clear all registers
//  sweep_busy   out  1       sweep in progress
//  sweep_done   out  1       single-cycle pulse after the last register is cleared
//  rf_load      out  1       register-file load strobe
//  rf_reset     out  1       register-file single-register reset strobe
//  rf_addr      out  ADDR_W  register-file write address (addr_a)
//  rf_d_in      out  DATA_W  register-file write data
//  grant_id     out  1       requester behind the current rf command (0/1)
// BEHAVIOUR
//  - Reset (reset_n=0): state=IDLE, rr_ptr=0 (req0 has priority), all registered outputs 0.
//    Effect is immediate and asynchronous. An in-progress sweep is aborted with no sweep_done.
//  - FSM states: IDLE, SWEEP.
//  - IDLE -> SWEEP on sweep_start. SWEEP -> IDLE after the command for addr NUM_REGS-1 is issued.
//  - Readiness: reqN_ready is combinational and is 1 only in IDLE, with sweep_start=0, and reqN granted.
//    At most one ready is high per cycle.
//  - Arbitration: if one requester is valid, grant it.
//    If both are valid, grant req[rr_ptr]; on an accepted handshake set rr_ptr = ~granted.
//    rr_ptr does not change when there is no handshake.
//  - Latency 1: an accepted command appears on the rf_* outputs on the next cycle, for exactly 1 cycle.
//    - clr=0: rf_load=1, rf_reset=0, rf_addr=addr, rf_d_in=data.
//    - clr=1: rf_reset=1, rf_load=0, rf_addr=addr, rf_d_in=0.
//  - rf_load and rf_reset are never both 1. With no command, both are 0 and rf_addr/rf_d_in hold their last values.
//  - Sweep ordering:
//    - Cycle after sweep_start: sweep_busy=1, rf_reset=1, rf_addr=0.
//    - rf_addr increments by 1 each cycle up to NUM_REGS-1 (NUM_REGS consecutive pulses).
//    - Next cycle: sweep_busy=0, sweep_done=1.
//    - A new request can be accepted in that same cycle; its rf command follows one cycle later.
//  - sweep_start wins over same-cycle requests: both readies are 0 and requesters hold their commands.
//  - sweep_start during SWEEP is ignored and does not restart or extend the sweep.
//  - Requesters must hold valid/addr/data/clr stable until ready; the arbiter does not latch unaccepted commands.
//  - The sweep counter is ADDR_W+1 bits wide so the terminal compare does not alias on wrap-around.
// STRUCTURE
//  - Shared package regfile_pkg: DATA_W/ADDR_W/NUM_REGS defaults, state encoding, REQ0/REQ1 ids.
//  - One natural sub-module: rr_arbiter2, a 2-way round-robin grant with the rr_ptr register.
//    The FSM, sweep counter and output registers stay in the top level.
// TESTING
//  - Reset: reset_n=0 mid-traffic -> all outputs 0 immediately; first request after release is granted to req0.
//  - Single writer: req0 valid, addr=3, data=8'hA5 -> req0_ready=1 that cycle;
//    next cycle rf_load=1, rf_addr=3, rf_d_in=A5; register 3 reads A5.
//  - Contention: both valid continuously, req0 addr=1/data=11, req1 addr=2/data=22 ->
//    grants alternate 0,1,0,1; one rf_load per cycle; grant_id matches.
//  - Clear: req1 valid, clr=1, addr=5 (register holds 7F) -> rf_reset=1, rf_load=0, rf_addr=5; register 5 reads 0.
//  - Sweep: preload all 8 registers with FF, pulse sweep_start while req0 is valid ->
//    req0 stalls; 8 rf_reset pulses, addr 0..7; sweep_done at cycle 9; req0 accepted in that cycle; all registers 0.
//  - Sweep abort/ignore: second sweep_start at addr 4 -> ignored.
//    reset_n low at addr 6 -> sweep_busy=0, no sweep_done, FSM in IDLE.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and encodings for the register-file write arbiter.
package regfile_pkg;

  localparam int unsigned DATA_W_DEF   = 8;
  localparam int unsigned ADDR_W_DEF   = 3;
  localparam int unsigned NUM_REGS_DEF = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; the pointer only moves when a grant is accepted.
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req_valid,
  input  logic       accept,
  output logic       grant_c,
  output logic       any_valid_c
);

  logic rr_ptr;

  always_comb begin
    any_valid_c = |req_valid;
    grant_c     = REQ0;
    if (&req_valid) begin
      grant_c = rr_ptr;
    end else if (req_valid[1]) begin
      grant_c = REQ1;
    end
  end

  // After a grant the other requester gets priority on the next tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= REQ0;
    end else if (accept) begin
      rr_ptr <= ~grant_c;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between two requesters and a
// clear-all sweep sequencer; rf_* outputs follow an accepted command by one cycle.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned NUM_REGS = NUM_REGS_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req0_clr,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              req1_clr,
  input  logic              sweep_start,
  output logic              sweep_busy,
  output logic              sweep_done,
  output logic              rf_load,
  output logic              rf_reset,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_d_in,
  output logic              grant_id
);

  // One extra bit so the terminal count NUM_REGS is distinct from address 0.
  localparam int unsigned CNT_W = ADDR_W + 1;

  state_t             state;
  logic [CNT_W-1:0]   sweep_cnt;
  logic               grant_c;
  logic               any_valid_c;
  logic               accept_c;
  logic [ADDR_W-1:0]  sel_addr_c;
  logic [DATA_W-1:0]  sel_data_c;
  logic               sel_clr_c;

  assign accept_c   = reset_n && (state == ST_IDLE) && !sweep_start && any_valid_c;
  assign req0_ready = accept_c && (grant_c == REQ0);
  assign req1_ready = accept_c && (grant_c == REQ1);

  assign sel_addr_c = (grant_c == REQ1) ? req1_addr : req0_addr;
  assign sel_data_c = (grant_c == REQ1) ? req1_data : req0_data;
  assign sel_clr_c  = (grant_c == REQ1) ? req1_clr  : req0_clr;

  rr_arbiter2 u_rr_arbiter2 (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   ({req1_valid, req0_valid}),
    .accept      (accept_c),
    .grant_c     (grant_c),
    .any_valid_c (any_valid_c)
  );

  // FSM, sweep counter and registered rf command outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      sweep_cnt  <= '0;
      sweep_busy <= 1'b0;
      sweep_done <= 1'b0;
      rf_load    <= 1'b0;
      rf_reset   <= 1'b0;
      rf_addr    <= '0;
      rf_d_in    <= '0;
      grant_id   <= 1'b0;
    end else begin
      rf_load    <= 1'b0;
      rf_reset   <= 1'b0;
      sweep_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (sweep_start) begin
            state      <= ST_SWEEP;
            sweep_busy <= 1'b1;
            rf_reset   <= 1'b1;
            rf_addr    <= '0;
            sweep_cnt  <= CNT_W'(1);
          end else if (accept_c) begin
            rf_load  <= ~sel_clr_c;
            rf_reset <= sel_clr_c;
            rf_addr  <= sel_addr_c;
            rf_d_in  <= sel_clr_c ? '0 : sel_data_c;
            grant_id <= grant_c;
          end
        end
        ST_SWEEP: begin
          if (sweep_cnt == CNT_W'(NUM_REGS)) begin
            state      <= ST_IDLE;
            sweep_busy <= 1'b0;
            sweep_done <= 1'b1;
          end else begin
            rf_reset  <= 1'b1;
            rf_addr   <= sweep_cnt[ADDR_W-1:0];
            sweep_cnt <= sweep_cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized and directed bench for regfile_write_arbiter against a queue-based
// reference model and a behavioural 8x8 register file hung off the rf_* outputs.
module tb_regfile_write_arbiter;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 3;
  localparam int unsigned NR = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req0_valid, req0_ready, req0_clr;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_data;
  logic          req1_valid, req1_ready, req1_clr;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_data;
  logic          sweep_start, sweep_busy, sweep_done;
  logic          rf_load, rf_reset, grant_id;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_d_in;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
    .req0_data(req0_data), .req0_clr(req0_clr),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
    .req1_data(req1_data), .req1_clr(req1_clr),
    .sweep_start(sweep_start), .sweep_busy(sweep_busy), .sweep_done(sweep_done),
    .rf_load(rf_load), .rf_reset(rf_reset), .rf_addr(rf_addr), .rf_d_in(rf_d_in),
    .grant_id(grant_id)
  );

  // Register file driven by the DUT outputs.
  logic [DW-1:0] rf_mem [NR];
  initial for (int i = 0; i < int'(NR); i++) rf_mem[i] = '0;
  always @(posedge clk) begin
    if (rf_load) rf_mem[rf_addr] <= rf_d_in;
    else if (rf_reset) rf_mem[rf_addr] <= '0;
  end

  // Reference model state.
  int            sweep_q [$];
  logic          m_rr;
  logic          e_load, e_reset, e_busy, e_done, e_gid;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;
  logic [DW-1:0] exp_mem [NR];
  logic          acc0, acc1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    sweep_q.delete();
    m_rr = 1'b0;
    e_load = 1'b0; e_reset = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_gid = 1'b0;
    e_addr = '0; e_data = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req0_ready"}, 32'(req0_ready), 32'(0));
    check({tag, "_req1_ready"}, 32'(req1_ready), 32'(0));
    check({tag, "_busy"},       32'(sweep_busy), 32'(0));
    check({tag, "_done"},       32'(sweep_done), 32'(0));
    check({tag, "_load"},       32'(rf_load),    32'(0));
    check({tag, "_reset"},      32'(rf_reset),   32'(0));
    check({tag, "_addr"},       32'(rf_addr),    32'(0));
    check({tag, "_d_in"},       32'(rf_d_in),    32'(0));
    check({tag, "_gid"},        32'(grant_id),   32'(0));
  endtask

  // Asserted away from the clock edge: outputs must clear without waiting for clk.
  task automatic assert_reset(input string tag);
    #2 reset_n = 1'b0;
    #1 check_all_zero(tag);
    model_reset();
  endtask

  task automatic release_reset();
    req0_valid = 1'b0; req1_valid = 1'b0; sweep_start = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic check_mem();
    for (int i = 0; i < int'(NR); i++)
      check($sformatf("mem%0d", i), 32'(rf_mem[i]), 32'(exp_mem[i]));
  endtask

  // One clock: check readiness mid-cycle, advance the model, check registered outputs.
  task automatic step();
    logic g, idle, r0, r1, clr;
    int   item;
    idle = (sweep_q.size() == 0);
    g    = (req0_valid && req1_valid) ? m_rr : req1_valid;
    r0   = idle && !sweep_start && (req0_valid || req1_valid) && (g == 1'b0);
    r1   = idle && !sweep_start && (req0_valid || req1_valid) && (g == 1'b1);
    @(negedge clk);
    check("req0_ready", 32'(req0_ready), 32'(r0));
    check("req1_ready", 32'(req1_ready), 32'(r1));
    acc0 = r0;
    acc1 = r1;
    if (e_load) exp_mem[e_addr] = e_data;
    else if (e_reset) exp_mem[e_addr] = '0;
    e_load = 1'b0; e_reset = 1'b0; e_done = 1'b0;
    if (!idle) begin
      item = sweep_q.pop_front();
      if (item < 0) begin
        e_busy = 1'b0; e_done = 1'b1;
      end else begin
        e_reset = 1'b1; e_addr = AW'(item);
      end
    end else if (sweep_start) begin
      for (int i = 0; i < int'(NR); i++) sweep_q.push_back(i);
      sweep_q.push_back(-1);
      item = sweep_q.pop_front();
      e_busy = 1'b1; e_reset = 1'b1; e_addr = AW'(item);
    end else if (r0 || r1) begin
      clr     = g ? req1_clr : req0_clr;
      e_gid   = g;
      e_addr  = g ? req1_addr : req0_addr;
      e_data  = clr ? '0 : (g ? req1_data : req0_data);
      e_load  = !clr;
      e_reset = clr;
      m_rr    = ~g;
    end
    @(posedge clk);
    #1;
    check("rf_load",    32'(rf_load),    32'(e_load));
    check("rf_reset",   32'(rf_reset),   32'(e_reset));
    check("rf_addr",    32'(rf_addr),    32'(e_addr));
    check("rf_d_in",    32'(rf_d_in),    32'(e_data));
    check("grant_id",   32'(grant_id),   32'(e_gid));
    check("sweep_busy", 32'(sweep_busy), 32'(e_busy));
    check("sweep_done", 32'(sweep_done), 32'(e_done));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, pulses;
    reset_n = 1'b0;
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0; req0_clr = 1'b0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0; req1_clr = 1'b0;
    sweep_start = 1'b0;
    acc0 = 1'b0; acc1 = 1'b0;
    for (int i = 0; i < int'(NR); i++) exp_mem[i] = '0;
    model_reset();
    #1 check_all_zero("por");
    release_reset();

    // Contention from reset: grants alternate starting with req0.
    req0_valid = 1'b1; req0_addr = 3'd1; req0_data = 8'h11; req0_clr = 1'b0;
    req1_valid = 1'b1; req1_addr = 3'd2; req1_data = 8'h22; req1_clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("cont_gid", 32'(grant_id), 32'(i % 2));
      check("cont_load", 32'(rf_load), 32'(1));
    end

    // Reset in the middle of traffic; first grant afterwards goes to req0.
    assert_reset("midtraffic");
    release_reset();
    req0_valid = 1'b1; req1_valid = 1'b1;
    step();
    check("first_grant", 32'(grant_id), 32'(0));
    req1_valid = 1'b0;

    // Single writer.
    req0_valid = 1'b1; req0_addr = 3'd3; req0_data = 8'hA5; req0_clr = 1'b0;
    step();
    check("single_addr", 32'(rf_addr), 32'(3));
    check("single_data", 32'(rf_d_in), 32'(8'hA5));
    req0_valid = 1'b0;
    step();
    check("reg3", 32'(rf_mem[3]), 32'(8'hA5));

    // Clear through req1.
    req1_valid = 1'b1; req1_addr = 3'd5; req1_data = 8'h7F; req1_clr = 1'b0;
    step();
    req1_clr = 1'b1; req1_data = 8'h3C;
    step();
    check("reg5_pre", 32'(rf_mem[5]), 32'(8'h7F));
    check("clr_reset", 32'(rf_reset), 32'(1));
    check("clr_load",  32'(rf_load),  32'(0));
    check("clr_addr",  32'(rf_addr),  32'(5));
    req1_valid = 1'b0; req1_clr = 1'b0;
    step();
    check("reg5", 32'(rf_mem[5]), 32'(0));

    // Sweep while req0 waits.
    for (int i = 0; i < int'(NR); i++) begin
      req0_valid = 1'b1; req0_addr = AW'(i); req0_data = 8'hFF; req0_clr = 1'b0;
      step();
    end
    req0_addr = 3'd2; req0_data = 8'h33;
    sweep_start = 1'b1;
    step();
    sweep_start = 1'b0;
    cyc = 1; pulses = 32'(rf_reset);
    while (!sweep_done && cyc < 12) begin
      step();
      cyc++;
      if (rf_reset) pulses++;
    end
    check("sweep_done_cycle", 32'(cyc), 32'(9));
    check("sweep_pulses", 32'(pulses), 32'(8));
    check("reg7_swept", 32'(rf_mem[7]), 32'(0));
    step();
    check("sweep_req0_acc", 32'(acc0), 32'(1));
    req0_valid = 1'b0;
    step();
    check_mem();

    // Second sweep_start at addr 4 is ignored; reset at addr 6 aborts.
    sweep_start = 1'b1;
    step();
    sweep_start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      sweep_start = rf_reset && (rf_addr == 3'd4);
      step();
      sweep_start = 1'b0;
      if (rf_reset && rf_addr == 3'd6) break;
    end
    check("abort_at6", 32'(rf_addr), 32'(6));
    assert_reset("abort");
    release_reset();
    for (int i = 0; i < 10; i++) step();
    req0_valid = 1'b1; req0_addr = 3'd4; req0_data = 8'h5A; req0_clr = 1'b0;
    step();
    check("idle_after_abort", 32'(acc0), 32'(1));
    req0_valid = 1'b0;

    // Randomized traffic with occasional sweeps.
    acc0 = 1'b1; acc1 = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (!req0_valid || acc0) begin
        req0_valid = ($urandom_range(0, 99) < 55);
        req0_addr  = AW'($urandom_range(0, 7));
        req0_data  = DW'($urandom);
        req0_clr   = ($urandom_range(0, 3) == 0);
      end
      if (!req1_valid || acc1) begin
        req1_valid = ($urandom_range(0, 99) < 55);
        req1_addr  = AW'($urandom_range(0, 7));
        req1_data  = DW'($urandom);
        req1_clr   = ($urandom_range(0, 3) == 0);
      end
      sweep_start = ($urandom_range(0, 29) == 0);
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0; sweep_start = 1'b0;
    for (int i = 0; i < 12; i++) step();
    check_mem();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
